// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-pipe result FIFOs feeding a single registered register-file write port.
// Optional macro WB_ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority (pipe 0 highest).
module wb_arbiter #(
    parameter int unsigned NUM_PIPES  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_PIPES-1:0]                              pipe_valid_i,
    output logic [NUM_PIPES-1:0]                              pipe_ready_o,
    input  logic [NUM_PIPES-1:0]                              pipe_wr_en_i,
    input  logic [NUM_PIPES*REG_WIDTH-1:0]                    pipe_rd_i,
    input  logic [NUM_PIPES*DATA_WIDTH-1:0]                   pipe_data_i,
    output logic                                              wb_valid_o,
    output logic                                              wb_wr_en_o,
    output logic [REG_WIDTH-1:0]                              wb_rd_o,
    output logic [DATA_WIDTH-1:0]                             wb_data_o,
    output logic [((NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1)-1:0] wb_pipe_id_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ID_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    typedef struct packed {
        logic                  wr_en;
        logic [REG_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    logic [NUM_PIPES-1:0] non_empty_c;
    logic [NUM_PIPES-1:0] pop_c;
    wb_entry_t            head_c [NUM_PIPES];
    logic                 grant_valid_c;
    logic [ID_W-1:0]      grant_id_c;
    wb_entry_t            grant_entry_c;

    // Per-pipe circular FIFO; ready is registered from the next occupancy so it depends on fill level only.
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_fifo
        wb_entry_t        mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_next_c;
        logic             ready_q;
        logic             push_c;

        assign push_c = pipe_valid_i[g] & ready_q;

        always_comb begin
            count_next_c = count;
            if (push_c && !pop_c[g]) begin
                count_next_c = count + CNT_W'(1);
            end else if (!push_c && pop_c[g]) begin
                count_next_c = count - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                ready_q <= 1'b1;
            end else begin
                if (push_c) begin
                    mem[wr_ptr] <= '{wr_en: pipe_wr_en_i[g],
                                     rd:    pipe_rd_i[g*REG_WIDTH +: REG_WIDTH],
                                     data:  pipe_data_i[g*DATA_WIDTH +: DATA_WIDTH]};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop_c[g]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count   <= count_next_c;
                ready_q <= (count_next_c != CNT_W'(FIFO_DEPTH));
            end
        end

        assign pipe_ready_o[g] = ready_q;
        assign non_empty_c[g]  = (count != '0);
        assign head_c[g]       = mem[rd_ptr];
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Search starts one past the last granted pipe.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_valid_c = 1'b0;
        grant_id_c    = '0;
        idx           = '0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % NUM_PIPES);
            if (!grant_valid_c && non_empty_c[idx]) begin
                grant_valid_c = 1'b1;
                grant_id_c    = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid_c) begin
            rr_ptr <= (grant_id_c == ID_W'(NUM_PIPES - 1)) ? '0 : grant_id_c + ID_W'(1);
        end
    end
`else
    // Lowest-index non-empty pipe wins.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_id_c    = '0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            if (!grant_valid_c && non_empty_c[ID_W'(i)]) begin
                grant_valid_c = 1'b1;
                grant_id_c    = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        pop_c = '0;
        if (grant_valid_c) begin
            pop_c[grant_id_c] = 1'b1;
        end
    end

    assign grant_entry_c = head_c[grant_id_c];

    // Registered write-back port; all fields forced to zero when nothing retires.
    always_ff @(posedge clk) begin
        if (rst || !grant_valid_c) begin
            wb_valid_o   <= 1'b0;
            wb_wr_en_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            wb_pipe_id_o <= '0;
        end else begin
            wb_valid_o   <= 1'b1;
            wb_wr_en_o   <= grant_entry_c.wr_en && (grant_entry_c.rd != '0);
            wb_rd_o      <= grant_entry_c.rd;
            wb_data_o    <= grant_entry_c.data;
            wb_pipe_id_o <= grant_id_c;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
// Round-robin checks compile in only when WB_ARB_ROUND_ROBIN_EN is defined.
module tb_wb_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    pipe_valid_i;
    logic [NP-1:0]    pipe_ready_o;
    logic [NP-1:0]    pipe_wr_en_i;
    logic [NP*RW-1:0] pipe_rd_i;
    logic [NP*DW-1:0] pipe_data_i;
    logic             wb_valid_o;
    logic             wb_wr_en_o;
    logic [RW-1:0]    wb_rd_o;
    logic [DW-1:0]    wb_data_o;
    logic [1:0]       wb_pipe_id_o;

    int n_cmp = 0;
    int n_mis = 0;

    wb_arbiter #(.NUM_PIPES(NP), .DATA_WIDTH(DW), .REG_WIDTH(RW), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_valid_i (pipe_valid_i),
        .pipe_ready_o (pipe_ready_o),
        .pipe_wr_en_i (pipe_wr_en_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .wb_valid_o   (wb_valid_o),
        .wb_wr_en_o   (wb_wr_en_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_pipe_id_o (wb_pipe_id_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic we,
                          input logic [RW-1:0] rd, input logic [DW-1:0] d, input logic [1:0] id);
        chk({tag, ".valid"}, 32'(wb_valid_o), 32'(v));
        chk({tag, ".wr_en"}, 32'(wb_wr_en_o), 32'(we));
        chk({tag, ".rd"},    32'(wb_rd_o),    32'(rd));
        chk({tag, ".data"},  wb_data_o,       d);
        chk({tag, ".id"},    32'(wb_pipe_id_o), 32'(id));
    endtask

    task automatic chk_idle(input string tag);
        chk_wb(tag, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_in();
        pipe_valid_i = '0;
        pipe_wr_en_i = '0;
        pipe_rd_i    = '0;
        pipe_data_i  = '0;
    endtask

    task automatic set_pipe(input int p, input logic we, input logic [RW-1:0] rd, input logic [DW-1:0] d);
        pipe_valid_i[p]          = 1'b1;
        pipe_wr_en_i[p]          = we;
        pipe_rd_i[p*RW +: RW]    = rd;
        pipe_data_i[p*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.ready", 32'(pipe_ready_o), 32'hF);
        chk_idle("rst");

        // Single retire from pipe 1, two-edge latency
        set_pipe(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        clear_in();
        chk("t1.lat", 32'(wb_valid_o), 32'd0);
        tick();
        chk_wb("t1", 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd1);
        tick();
        chk_idle("t1.after");

        // rd == 0 suppresses the register-file write
        set_pipe(0, 1'b1, 5'd0, 32'h1234_5678);
        tick();
        clear_in();
        tick();
        chk_wb("t2", 1'b1, 1'b0, 5'd0, 32'h1234_5678, 2'd0);
        tick();
        chk_idle("t2.after");

        // Pipe 2 streams three entries alone; ready never drops
        set_pipe(2, 1'b1, 5'd3, 32'hA000_0000);
        chk("t3.rdy0", 32'(pipe_ready_o[2]), 32'd1);
        tick();
        chk_idle("t3.e0");
        set_pipe(2, 1'b1, 5'd4, 32'hA000_0001);
        chk("t3.rdy1", 32'(pipe_ready_o[2]), 32'd1);
        tick();
        chk_wb("t3.e1", 1'b1, 1'b1, 5'd3, 32'hA000_0000, 2'd2);
        set_pipe(2, 1'b0, 5'd5, 32'hA000_0002);
        chk("t3.rdy2", 32'(pipe_ready_o[2]), 32'd1);
        tick();
        clear_in();
        chk_wb("t3.e2", 1'b1, 1'b1, 5'd4, 32'hA000_0001, 2'd2);
        chk("t3.rdy3", 32'(pipe_ready_o[2]), 32'd1);
        tick();
        chk_wb("t3.e3", 1'b1, 1'b0, 5'd5, 32'hA000_0002, 2'd2);
        tick();
        chk_idle("t3.e4");

`ifndef WB_ARB_ROUND_ROBIN_EN
        // Pipes 0/1 hog the port under fixed priority; pipe 2 fills and its third value waits
        set_pipe(0, 1'b1, 5'd1, 32'h0000_0100);
        set_pipe(1, 1'b1, 5'd2, 32'h0000_0200);
        set_pipe(2, 1'b1, 5'd3, 32'hC000_0000);
        tick();
        set_pipe(2, 1'b1, 5'd3, 32'hC000_0001);
        tick();
        chk("t3b.rdy.e1", 32'(pipe_ready_o[2]), 32'd0);
        chk("t3b.id.e1", 32'(wb_pipe_id_o), 32'd0);
        set_pipe(2, 1'b1, 5'd3, 32'hC000_0002);
        tick();
        chk("t3b.rdy.e2", 32'(pipe_ready_o[2]), 32'd0);
        chk("t3b.id.e2", 32'(wb_pipe_id_o), 32'd0);
        pipe_valid_i[0] = 1'b0;
        pipe_valid_i[1] = 1'b0;
        tick();
        chk("t3b.rdy.e3", 32'(pipe_ready_o[2]), 32'd0);
        chk_wb("t3b.e3", 1'b1, 1'b1, 5'd1, 32'h0000_0100, 2'd0);
        tick();
        chk("t3b.rdy.e4", 32'(pipe_ready_o[2]), 32'd0);
        chk_wb("t3b.e4", 1'b1, 1'b1, 5'd2, 32'h0000_0200, 2'd1);
        tick();
        chk("t3b.rdy.e5", 32'(pipe_ready_o[2]), 32'd0);
        chk("t3b.id.e5", 32'(wb_pipe_id_o), 32'd1);
        tick();
        chk("t3b.rdy.e6", 32'(pipe_ready_o[2]), 32'd1);
        chk_wb("t3b.e6", 1'b1, 1'b1, 5'd3, 32'hC000_0000, 2'd2);
        tick();
        clear_in();
        chk("t3b.rdy.e7", 32'(pipe_ready_o[2]), 32'd1);
        chk_wb("t3b.e7", 1'b1, 1'b1, 5'd3, 32'hC000_0001, 2'd2);
        tick();
        chk_wb("t3b.e8", 1'b1, 1'b1, 5'd3, 32'hC000_0002, 2'd2);
        tick();
        chk_idle("t3b.e9");
`endif

        // All four pipes push together; retire in order 0..3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) begin
            set_pipe(p, 1'b1, 5'(p + 8), 32'hB000_0000 + 32'(p));
        end
        tick();
        clear_in();
        for (int p = 0; p < 4; p++) begin
            tick();
            chk_wb($sformatf("t4.p%0d", p), 1'b1, 1'b1, 5'(p + 8), 32'hB000_0000 + 32'(p), 2'(p));
        end
        tick();
        chk_idle("t4.after");

`ifdef WB_ARB_ROUND_ROBIN_EN
        // Pipes 0 and 3 stay busy; round-robin alternates between them
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_pipe(0, 1'b1, 5'd1, 32'h0);
        set_pipe(3, 1'b1, 5'd2, 32'h3);
        tick();
        tick();
        chk("rr.g0", 32'(wb_pipe_id_o), 32'd0);
        tick();
        chk("rr.g1", 32'(wb_pipe_id_o), 32'd3);
        tick();
        chk("rr.g2", 32'(wb_pipe_id_o), 32'd0);
        tick();
        chk("rr.g3", 32'(wb_pipe_id_o), 32'd3);
        clear_in();
`endif

        // Reset while two FIFOs hold entries; in-flight push and pop are discarded
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_pipe(1, 1'b1, 5'd9, 32'h1111_1111);
        set_pipe(2, 1'b1, 5'd10, 32'h2222_2222);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        chk("t5.ready", 32'(pipe_ready_o), 32'hF);
        chk_idle("t5.e1");
        tick();
        chk_idle("t5.e2");
        chk("t5.ready2", 32'(pipe_ready_o), 32'hF);
        tick();
        chk_idle("t5.e3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
